spwtcr_rx_buffer: RTL and testbench
===================================

SPWTCR_RX_BUFFER -- requirements
Module: spwtcr_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 64, FIFO word capacity; power of two, 16..1024.
REQ-002 Derived constant AW = log2(DEPTH), pointer width.
REQ-003 CLOCK  input  1  single clock; all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 rx_req  input  1  receiver write request, four-phase; rx_data stable while high.
REQ-006 rx_data  input  9  received character; bit 8 = control flag (EOP/EEP), bits 7:0 = data.
REQ-007 rx_ack  output  1  write acknowledge to receiver.
REQ-008 re  input  1  user read strobe, possibly asynchronous; one rising edge = one pop.
REQ-009 data_o  output  9  registered head word.
REQ-010 empty  output  1  FIFO holds zero words.
REQ-011 full  output  1  FIFO holds DEPTH words.
REQ-012 fct_slots  output  AW-2  free space in 8-character groups, floor((DEPTH-count)/8), saturating at 2^(AW-2)-1.
REQ-013 ovf  output  1  sticky overflow flag (only with SPWTCR_RX_OVF_EN, else tied 0).

Function
REQ-014 Write FSM states: W_IDLE, W_STORE, W_ACK.
REQ-015 W_IDLE -> W_STORE when rx_req=1 and full=0; otherwise stay in W_IDLE.
REQ-016 W_STORE: rx_data written at write pointer, write pointer +1 mod DEPTH, count +1; unconditional -> W_ACK next cycle.
REQ-017 W_ACK: rx_ack=1; -> W_IDLE when rx_req=0, else stay.
REQ-018 rx_ack is 1 only in W_ACK; request-to-ack latency is 2 cycles when not full.
REQ-019 When full, the request is held pending without ack; the write proceeds on the first cycle full deasserts.
REQ-020 re passes through a 2-flop synchronizer; pop event = sync1 & !sync2 (rising edge, 3-cycle latency from re).
REQ-021 Pop with empty=0: data_o <= word at read pointer, read pointer +1 mod DEPTH, count -1; data_o valid the cycle after the pop event.
REQ-022 Pop with empty=1 is ignored; data_o, pointers and count unchanged.
REQ-023 Simultaneous W_STORE and pop: both pointers advance, count unchanged; when full, a same-cycle pop does not enable W_STORE until the next cycle.
REQ-024 Count is AW+1 bits; empty = (count==0), full = (count==DEPTH), both combinational from registered count.
REQ-025 Pointers wrap from DEPTH-1 to 0 without a gap.
REQ-026 fct_slots registered, updates one cycle after count changes.

Reset
REQ-027 On RESET: FSM=W_IDLE, pointers=0, count=0, sync flops=0, data_o=0, rx_ack=0, ovf=0.
REQ-028 Derived outputs after RESET: empty=1, full=0, fct_slots=maximum value.
REQ-029 RESET during W_STORE or W_ACK discards any in-flight word; the receiver must re-request.
REQ-030 Storage array contents are not reset.

Configuration
REQ-031 Macro SPWTCR_RX_OVF_EN defined: ovf set when rx_req=1 and full=1 in W_IDLE for 2 consecutive cycles; cleared only by RESET.
REQ-032 Macro not defined: no overflow logic, ovf constant 0; all other behaviour identical.

Structure
REQ-033 Shared package spwtcr_pkg holds the write-FSM enum type and the 9-bit character width and control-bit-index constants.
REQ-034 Single sub-module spwtcr_sync2: 2-flop synchronizer with async active-high reset, used for re.
REQ-035 Storage is an inferred register array; no vendor FIFO IP.

Verification
REQ-036 Reset, then rx_req=1 with rx_data=0x041 -> rx_ack high 2 cycles later; empty=0; count=1.
REQ-037 Write 0x041, 0x142 (EOP), pulse re twice -> data_o=0x041 then 0x142, empty=1 after second pop.
REQ-038 DEPTH=16: write 16 words -> full=1, fct_slots=0; 17th rx_req -> no ack until one pop, then ack within 2 cycles after the pop takes effect.
REQ-039 Fill 15, then rx_req and re edge aligned to hit the same cycle -> count stays 15, order preserved.
REQ-040 Write/read 40 words through DEPTH=16 -> pointer wrap, read sequence equals write sequence.
REQ-041 With SPWTCR_RX_OVF_EN, hold rx_req 3 cycles while full -> ovf=1 and stays 1 after draining; without the macro ovf=0.

Source files
------------

// File: rtl/spwtcr_pkg.sv
// rtl/spwtcr_pkg.sv - shared types and constants for the SpaceWire receive buffer
package spwtcr_pkg;

    localparam int CHAR_W   = 9;
    localparam int CTRL_BIT = 8;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_STORE = 2'd1,
        W_ACK   = 2'd2
    } w_state_t;

endpackage

// File: rtl/spwtcr_sync2.sv
// rtl/spwtcr_sync2.sv - two-flop synchronizer for a single asynchronous bit
module spwtcr_sync2 (
    input  logic CLOCK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spwtcr_rx_buffer.sv
// rtl/spwtcr_rx_buffer.sv - receive character FIFO with four-phase write side and async read strobe
// Optional sticky overflow flag enabled by SPWTCR_RX_OVF_EN.
module spwtcr_rx_buffer
    import spwtcr_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              rx_req,
    input  logic [CHAR_W-1:0] rx_data,
    output logic              rx_ack,
    input  logic              re,
    output logic [CHAR_W-1:0] data_o,
    output logic              empty,
    output logic              full,
    output logic [AW-3:0]     fct_slots,
    output logic              ovf
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-3:0] FCT_RST   = (AW-2)'(DEPTH / 8);

    w_state_t          state;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [AW:0]       free_words;
    logic              re_s;
    logic              re_q;
    logic              pop_ev;
    logic              do_pop;
    logic              do_store;
    logic [CHAR_W-1:0] mem [DEPTH];

    spwtcr_sync2 u_re_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .d     (re),
        .q     (re_s)
    );

    assign pop_ev     = re_s & ~re_q;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_CNT);
    assign do_pop     = pop_ev & ~empty;
    assign do_store   = (state == W_STORE);
    assign free_words = DEPTH_CNT - count;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= W_IDLE;
            rx_ack <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (rx_req && !full)
                        state <= W_STORE;
                end
                W_STORE: begin
                    state  <= W_ACK;
                    rx_ack <= 1'b1;
                end
                W_ACK: begin
                    if (!rx_req) begin
                        state  <= W_IDLE;
                        rx_ack <= 1'b0;
                    end
                end
                default: begin
                    state  <= W_IDLE;
                    rx_ack <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge CLOCK) begin
        if (do_store)
            mem[wptr] <= rx_data;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            re_q      <= 1'b0;
            data_o    <= '0;
            fct_slots <= FCT_RST;
        end else begin
            re_q <= re_s;
            if (do_store)
                wptr <= wptr + 1'b1;
            if (do_pop) begin
                data_o <= mem[rptr];
                rptr   <= rptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_store} - {{AW{1'b0}}, do_pop};
            // DEPTH/8 always fits in AW-2 bits, so the group count never needs clamping.
            fct_slots <= free_words[AW:3];
        end
    end

`ifdef SPWTCR_RX_OVF_EN
    logic blocked;
    logic blocked_q;

    assign blocked = (state == W_IDLE) && rx_req && full;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            blocked_q <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            blocked_q <= blocked;
            if (blocked && blocked_q)
                ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_spwtcr_rx_buffer.sv
// tb/tb_spwtcr_rx_buffer.sv - self-checking bench for spwtcr_rx_buffer with a queue reference model
module tb_spwtcr_rx_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef SPWTCR_RX_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          rx_req = 1'b0;
    logic [8:0]    rx_data = '0;
    logic          rx_ack;
    logic          re = 1'b0;
    logic [8:0]    data_o;
    logic          empty;
    logic          full;
    logic [AW-3:0] fct_slots;
    logic          ovf;

    int            checks = 0;
    int            failures = 0;
    logic [8:0]    model_q[$];
    logic [8:0]    model_dout = '0;
    bit            model_ovf = 1'b0;

    spwtcr_rx_buffer #(.DEPTH(DEPTH)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .rx_req    (rx_req),
        .rx_data   (rx_data),
        .rx_ack    (rx_ack),
        .re        (re),
        .data_o    (data_o),
        .empty     (empty),
        .full      (full),
        .fct_slots (fct_slots),
        .ovf       (ovf)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic int fct_exp(input int n);
        int v;
        v = (DEPTH - n) / 8;
        if (v > (1 << (AW - 2)) - 1)
            v = (1 << (AW - 2)) - 1;
        return v;
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
        chk({tag, "_fct"}, 32'(fct_slots), 32'(fct_exp(model_q.size())));
        chk({tag, "_ovf"}, 32'(ovf), 32'(model_ovf));
    endtask

    task automatic write_word(input logic [8:0] d);
        int cyc;
        rx_req  = 1'b1;
        rx_data = d;
        cyc = 0;
        while (!rx_ack && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("ack_latency", 32'(cyc), 32'd2);
        model_q.push_back(d);
        rx_req = 1'b0;
        tick();
        chk("ack_release", 32'(rx_ack), 32'd0);
    endtask

    task automatic pop_word();
        re = 1'b1;
        repeat (3) tick();
        if (model_q.size() > 0)
            model_dout = model_q.pop_front();
        chk("pop_data", 32'(data_o), 32'(model_dout));
        re = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [8:0] d;
        int cyc;
        int written;

        repeat (3) tick();
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_rx_ack", 32'(rx_ack), 32'd0);
        check_flags("rst");
        RESET = 1'b0;
        tick();
        check_flags("post_rst");

        write_word(9'h041);
        check_flags("first_write");

        write_word(9'h142);
        check_flags("second_write");
        pop_word();
        chk("pop1_value", 32'(data_o), 32'h041);
        pop_word();
        chk("pop2_value", 32'(data_o), 32'h142);
        check_flags("after_two_pops");

        pop_word();
        check_flags("pop_on_empty");

        for (int i = 0; i < DEPTH; i++) begin
            write_word(9'($urandom));
        end
        check_flags("filled");

        d = 9'($urandom);
        rx_req  = 1'b1;
        rx_data = d;
        repeat (3) tick();
        chk("full_no_ack", 32'(rx_ack), 32'd0);
        model_ovf = OVF_ON;
        chk("ovf_full_hold", 32'(ovf), 32'(model_ovf));
        re = 1'b1;
        cyc = 0;
        while (!rx_ack && cyc < 12) begin
            tick();
            cyc++;
            if (cyc == 3) begin
                model_dout = model_q.pop_front();
                chk("full_pop_data", 32'(data_o), 32'(model_dout));
                chk("full_pop_clear", 32'(full), 32'd0);
                chk("full_pop_noack", 32'(rx_ack), 32'd0);
            end
        end
        chk("full_release_lat", 32'(cyc), 32'd5);
        model_q.push_back(d);
        rx_req = 1'b0;
        re     = 1'b0;
        repeat (3) tick();
        check_flags("refilled");

        while (model_q.size() > 0)
            pop_word();
        check_flags("drained");

        for (int i = 0; i < DEPTH - 1; i++) begin
            write_word(9'($urandom));
        end
        check_flags("fill15");
        d  = 9'($urandom);
        re = 1'b1;
        tick();
        rx_req  = 1'b1;
        rx_data = d;
        tick();
        tick();
        model_dout = model_q.pop_front();
        model_q.push_back(d);
        chk("same_cycle_ack", 32'(rx_ack), 32'd1);
        chk("same_cycle_data", 32'(data_o), 32'(model_dout));
        chk("same_cycle_full", 32'(full), 32'd0);
        rx_req = 1'b0;
        re     = 1'b0;
        repeat (3) tick();
        check_flags("same_cycle");
        while (model_q.size() > 0)
            pop_word();
        check_flags("same_cycle_drain");

        written = 0;
        while (written < 40 || model_q.size() > 0) begin
            if (written < 40 && model_q.size() < DEPTH &&
                (model_q.size() == 0 || $urandom_range(0, 2) != 0)) begin
                write_word(9'($urandom));
                written++;
            end else begin
                pop_word();
            end
        end
        check_flags("stream40");

        write_word(9'h0AA);
        rx_req  = 1'b1;
        rx_data = 9'h155;
        repeat (2) tick();
        RESET  = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(rx_ack), 32'd0);
        rx_req = 1'b0;
        model_q.delete();
        model_dout = '0;
        model_ovf  = 1'b0;
        chk("rst_mid_data", 32'(data_o), 32'd0);
        check_flags("rst_mid");
        tick();
        RESET = 1'b0;
        repeat (2) tick();
        check_flags("after_mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
